i2s_tx_serializer: RTL and testbench

- Transmit-side serializer of the I2S transceiver. It sits directly downstream of the control package's operating-mode struct (OP_t in ctrl_pkg) and consumes its word_size, frame_size, standard and mode fields.
- Accepts stereo PCM samples over a valid/ready handshake and shifts them out MSB-first on sd_out, timed by bit-clock falling-edge strobes from the clock generator.
- Drives WS in master-transmit mode; follows an external WS in slave-transmit mode.

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/i2s_tx_bitsel.sv | 48 ++++
 rtl/i2s_tx_serializer.sv | 149 ++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Control package: operating-mode struct shared by the I2S transceiver blocks.
// It also holds the frame and word width constants and their decode helpers.
package ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_ST = 2'b01,
    MODE_MR = 2'b10,
    MODE_MT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    STD_I2S = 2'b00,
    STD_MSB = 2'b01,
    STD_LSB = 2'b10,
    STD_RSV = 2'b11
  } std_e;

  // mode[0] = transmit, mode[1] = master
  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] standard;
    logic       frame_size;
    logic [1:0] word_size;
  } OP_t;

  localparam int unsigned FRAME_W16 = 16;
  localparam int unsigned FRAME_W32 = 32;
  localparam int unsigned WORD_W16  = 16;
  localparam int unsigned WORD_W24  = 24;
  localparam int unsigned WORD_W32  = 32;

  function automatic logic [5:0] frame_bits(input logic fs);
    return fs ? 6'(FRAME_W32) : 6'(FRAME_W16);
  endfunction

  // reserved code 2'b11 decodes as a 32-bit word
  function automatic logic [5:0] word_bits(input logic [1:0] ws);
    case (ws)
      2'b00:   return 6'(WORD_W16);
      2'b01:   return 6'(WORD_W24);
      default: return 6'(WORD_W32);
    endcase
  endfunction

endpackage

// File: rtl/i2s_tx_bitsel.sv
// Combinational selection of the serial bit for slot position p.
// It handles the MSB-justified, LSB-justified and I2S (one-bit delayed) layouts.
module i2s_tx_bitsel
  import ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] word,
  input  logic [4:0]    p,
  input  logic [5:0]    we,
  input  logic [5:0]    f,
  input  logic [1:0]    standard,
  input  logic          prev_lsb,
  output logic          sd
);

  logic [5:0]    pe;
  logic [5:0]    idx;
  logic          hit;
  logic [DW-1:0] sh;

  always_comb begin
    pe  = {1'b0, p};
    idx = '0;
    hit = 1'b0;
    sd  = 1'b0;
    case (standard)
      STD_MSB: begin
        hit = pe < we;
        idx = we - 6'd1 - pe;
      end
      STD_LSB: begin
        hit = pe >= (f - we);
        idx = f - 6'd1 - pe;
      end
      default: begin
        hit = (pe != 6'd0) && (pe <= we);
        idx = we - pe;
      end
    endcase
    sh = word >> idx;
    if (hit)
      sd = sh[0];
    else if (standard != STD_MSB && standard != STD_LSB && pe == 6'd0 && we == f)
      sd = prev_lsb;
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: buffers one stereo pair and shifts it out MSB-first on SCK falling edges.
// It generates WS as master and follows an external WS as slave.
module i2s_tx_serializer
  import ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  OP_t           op,
  input  logic          sck_fe,
  input  logic          ws_in,
  output logic          ws_out,
  output logic          sd_out,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_left,
  input  logic [DW-1:0] s_right,
  output logic          underrun,
  output logic          busy
);

  OP_t           cfg;
  logic          en_q, run, master, hs;
  logic [4:0]    p, p_nx, fm1;
  logic          ch, ch_nx, started, started_nx, synced, synced_nx, ws_prev, ws_prev_nx;
  logic          emit, frame_start, bit_nx, prev_lsb;
  logic          pend_valid;
  logic [DW-1:0] pend_l, pend_r, act_l, act_r, act_l_nx, act_r_nx, cur_w, prev_w;
  logic [5:0]    f, w, we, shamt;

  assign f       = frame_bits(cfg.frame_size);
  assign w       = word_bits(cfg.word_size);
  assign we      = (w > f) ? f : w;
  assign shamt   = (w > f) ? (w - f) : 6'd0;
  assign fm1     = 5'(f - 6'd1);
  assign run     = en && en_q && cfg.mode[0];
  assign master  = cfg.mode[1];
  assign busy    = run;
  assign s_ready = !pend_valid;
  assign hs      = s_valid && s_ready;

  always_comb begin
    p_nx       = p;
    ch_nx      = ch;
    started_nx = started;
    synced_nx  = synced;
    ws_prev_nx = ws_prev;
    if (sck_fe) begin
      started_nx = 1'b1;
      if (master) begin
        if (!started) begin
          p_nx  = '0;
          ch_nx = 1'b0;
        end else if (p == fm1) begin
          p_nx  = '0;
          ch_nx = !ch;
        end else begin
          p_nx = p + 5'd1;
        end
      end else begin
        ws_prev_nx = ws_in;
        if (started && ws_in != ws_prev) begin
          p_nx      = '0;
          ch_nx     = ws_in;
          synced_nx = 1'b1;
        end else if (p != fm1) begin
          p_nx = p + 5'd1;
        end
      end
    end
    emit        = run && sck_fe && (master || synced_nx);
    frame_start = emit && p_nx == 5'd0 && !ch_nx;
    act_l_nx    = frame_start ? (pend_valid ? pend_l : '0) : act_l;
    act_r_nx    = frame_start ? (pend_valid ? pend_r : '0) : act_r;
    cur_w       = (ch_nx ? act_r_nx : act_l_nx) >> shamt;
    prev_w      = (ch ? act_r : act_l) >> shamt;
    prev_lsb    = prev_w[0];
  end

  i2s_tx_bitsel #(.DW(DW)) u_bitsel (
    .word     (cur_w),
    .p        (p_nx),
    .we       (we),
    .f        (f),
    .standard (cfg.standard),
    .prev_lsb (prev_lsb),
    .sd       (bit_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg        <= '0;
      en_q       <= 1'b0;
      p          <= '0;
      ch         <= 1'b0;
      started    <= 1'b0;
      synced     <= 1'b0;
      ws_prev    <= 1'b0;
      ws_out     <= 1'b0;
      sd_out     <= 1'b0;
      underrun   <= 1'b0;
      pend_valid <= 1'b0;
      pend_l     <= '0;
      pend_r     <= '0;
      act_l      <= '0;
      act_r      <= '0;
    end else begin
      en_q <= en;
      if (en && !en_q)
        cfg <= op;
      // the handshake stays live whether or not the serializer is running
      if (hs) begin
        pend_valid <= 1'b1;
        pend_l     <= s_left;
        pend_r     <= s_right;
      end else if (frame_start && pend_valid) begin
        pend_valid <= 1'b0;
      end
      if (!run) begin
        p        <= '0;
        ch       <= 1'b0;
        started  <= 1'b0;
        synced   <= 1'b0;
        ws_prev  <= 1'b0;
        ws_out   <= 1'b0;
        sd_out   <= 1'b0;
        underrun <= 1'b0;
        act_l    <= '0;
        act_r    <= '0;
      end else begin
        p        <= p_nx;
        ch       <= ch_nx;
        started  <= started_nx;
        synced   <= synced_nx;
        ws_prev  <= ws_prev_nx;
        act_l    <= act_l_nx;
        act_r    <= act_r_nx;
        underrun <= frame_start && !pend_valid;
        if (sck_fe) begin
          sd_out <= emit ? bit_nx : 1'b0;
          ws_out <= master ? ch_nx : 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: hand-computed serial words per mode/standard,
// underrun, pending buffer, en drop and asynchronous reset.
module tb_i2s_tx_serializer;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, sck_fe, ws_in, s_valid;
  OP_t         op;
  logic        ws_out, sd_out, s_ready, underrun, busy;
  logic [31:0] s_left, s_right;

  int n_chk = 0;
  int n_fail = 0;

  logic        sd_s, ws_s, ur_s, ur2_s;
  logic [31:0] acc_sd, acc_ws;

  i2s_tx_serializer #(.DW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .op       (op),
    .sck_fe   (sck_fe),
    .ws_in    (ws_in),
    .ws_out   (ws_out),
    .sd_out   (sd_out),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_left   (s_left),
    .s_right  (s_right),
    .underrun (underrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic OP_t mk_op(input logic [1:0] mode, input logic [1:0] std_v,
                                input logic fs, input logic [1:0] ws);
    OP_t o;
    o.mode       = mode;
    o.standard   = std_v;
    o.frame_size = fs;
    o.word_size  = ws;
    return o;
  endfunction

  // one SCK falling-edge strobe; samples outputs after the strobe edge and one clk later
  task automatic tick();
    @(negedge clk) sck_fe = 1'b1;
    @(negedge clk) sck_fe = 1'b0;
    sd_s = sd_out;
    ws_s = ws_out;
    ur_s = underrun;
    @(negedge clk) ur2_s = underrun;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    acc_sd = '0;
    acc_ws = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      acc_sd = {acc_sd[30:0], sd_s};
      acc_ws = {acc_ws[30:0], ws_s};
    end
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r);
    int n;
    n = 0;
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    while (!s_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 32'(n < 1000), 32'd1);
    @(negedge clk) s_valid = 1'b0;
  endtask

  task automatic start(input OP_t o);
    @(negedge clk) en = 1'b0;
    op = o;
    @(negedge clk) en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sck_fe = 1'b0; ws_in = 1'b0; s_valid = 1'b0;
    s_left = '0; s_right = '0; op = '0;
    sd_s = 0; ws_s = 0; ur_s = 0; ur2_s = 0; acc_sd = '0; acc_ws = '0;
    repeat (3) @(negedge clk);
    chk("rst_sd", 32'(sd_out), 32'd0);
    chk("rst_ws", 32'(ws_out), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MT, MSB, w16/f16
    send(32'h0000_A5F0, 32'h0000_0F0F);
    chk("pend_ready_low", 32'(s_ready), 32'd0);
    start(mk_op(2'b11, 2'b01, 1'b0, 2'b00));
    chk("mt_busy", 32'(busy), 32'd1);
    ticks(16);
    chk("mt_msb_left", acc_sd, 32'h0000_A5F0);
    chk("mt_msb_ws_left", acc_ws, 32'h0000_0000);
    ticks(16);
    chk("mt_msb_right", acc_sd, 32'h0000_0F0F);
    chk("mt_msb_ws_right", acc_ws, 32'h0000_FFFF);

    // next frame has nothing pending; a pair arrives mid-frame
    tick();
    chk("underrun_pulse", 32'(ur_s), 32'd1);
    chk("underrun_one_clk", 32'(ur2_s), 32'd0);
    chk("underrun_sd", 32'(sd_s), 32'd0);
    ticks(9);
    send(32'h0000_1234, 32'h0000_5678);
    chk("midframe_ready_low", 32'(s_ready), 32'd0);
    ticks(22);
    chk("underrun_frame_zero", acc_sd, 32'h0000_0000);
    ticks(16);
    chk("next_frame_left", acc_sd, 32'h0000_1234);
    chk("pend_consumed", 32'(s_ready), 32'd1);
    ticks(16);
    chk("next_frame_right", acc_sd, 32'h0000_5678);

    // MT, I2S, w24/f32
    send(32'h0080_0001, 32'h0000_0000);
    start(mk_op(2'b11, 2'b00, 1'b1, 2'b01));
    ticks(32);
    chk("i2s_w24_left", acc_sd, 32'h4000_0080);
    chk("i2s_w24_ws_left", acc_ws, 32'h0000_0000);
    ticks(32);
    chk("i2s_w24_right", acc_sd, 32'h0000_0000);
    chk("i2s_w24_ws_right", acc_ws, 32'hFFFF_FFFF);

    // MT, I2S, w16/f16: p0 carries the LSB of the previous channel
    send(32'h0000_0001, 32'h0000_8000);
    start(mk_op(2'b11, 2'b00, 1'b0, 2'b00));
    ticks(16);
    chk("i2s_full_left", acc_sd, 32'h0000_0000);
    ticks(16);
    chk("i2s_full_right", acc_sd, 32'h0000_C000);

    // MT, LSB, w16/f32
    send(32'h0000_8001, 32'h0000_FFFF);
    start(mk_op(2'b11, 2'b10, 1'b1, 2'b00));
    ticks(32);
    chk("lsb_left", acc_sd, 32'h0000_8001);
    ticks(32);
    chk("lsb_right", acc_sd, 32'h0000_FFFF);

    // ST, MSB, w32/f16: top 16 bits sent, silent until first ws_in edge
    send(32'h1234_5678, 32'h9ABC_DEF0);
    ws_in = 1'b1;
    start(mk_op(2'b01, 2'b01, 1'b0, 2'b10));
    ticks(5);
    chk("st_presync_sd", acc_sd, 32'h0000_0000);
    chk("st_ws_out", acc_ws, 32'h0000_0000);
    ws_in = 1'b0;
    ticks(16);
    chk("st_left", acc_sd, 32'h0000_1234);
    ws_in = 1'b1;
    ticks(16);
    chk("st_right", acc_sd, 32'h0000_9ABC);

    // en drop mid-frame keeps the pending pair
    send(32'h0000_0000, 32'h0000_FFFF);
    start(mk_op(2'b11, 2'b01, 1'b0, 2'b00));
    ticks(20);
    chk("pre_drop_sd", 32'(sd_s), 32'd1);
    chk("pre_drop_ws", 32'(ws_s), 32'd1);
    send(32'h0000_FFFF, 32'h0000_FFFF);
    @(negedge clk) en = 1'b0;
    @(negedge clk);
    chk("drop_sd", 32'(sd_out), 32'd0);
    chk("drop_ws", 32'(ws_out), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_pend_kept", 32'(s_ready), 32'd0);
    start(mk_op(2'b11, 2'b01, 1'b0, 2'b00));
    tick();
    chk("reen_sd", 32'(sd_s), 32'd1);
    chk("reen_no_underrun", 32'(ur_s), 32'd0);
    chk("reen_ready", 32'(s_ready), 32'd1);

    // asynchronous reset mid-frame
    send(32'h0000_FFFF, 32'h0000_FFFF);
    ticks(3);
    chk("pre_rst_sd", 32'(sd_s), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sd", 32'(sd_out), 32'd0);
    chk("arst_ws", 32'(ws_out), 32'd0);
    chk("arst_ready", 32'(s_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
